// File: rtl/sd_spi_ctrl.sv
// SD-card SPI master on the CPU IO bus.
// One DATA write shifts a full byte out and in, mode 0, MSB first.
module sd_spi_ctrl #(
    parameter logic [7:0] RESET_DIV = 8'd45
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] cpu_addr,
    input  logic       cpu_wr,
    input  logic [7:0] cpu_din,
    output logic [7:0] cpu_dout,
    output logic       sd_clk,
    output logic       sd_mosi,
    output logic       sd_ssel_n,
    input  logic       sd_miso,
    input  logic       sd_det,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } state_t;

    state_t     r_state;
    logic [7:0] r_div;
    logic [7:0] r_cnt;
    logic [2:0] r_bit;
    logic [7:0] r_tx;
    logic [7:0] r_rxsh;
    logic [7:0] r_rx;
    logic       r_sclk;
    logic       r_mosi;
    logic       r_busy;
    logic       r_ovr;
    logic       r_ssel;

    logic w_wr_data;
    logic w_wr_ctrl;
    logic w_wr_div;
    logic w_idle;
    logic w_start;

    assign w_wr_data = cpu_wr && (cpu_addr == 2'd0);
    assign w_wr_ctrl = cpu_wr && (cpu_addr == 2'd1);
    assign w_wr_div  = cpu_wr && (cpu_addr == 2'd2);
    assign w_idle    = (r_state == ST_IDLE);
    assign w_start   = w_wr_data && w_idle;

    assign sd_clk    = r_sclk;
    assign sd_mosi   = r_mosi;
    assign sd_ssel_n = r_ssel;
    assign busy      = r_busy;

    // CPU read mux, combinational on the address
    always_comb begin
        cpu_dout = 8'h00;
        unique case (cpu_addr)
            2'd0:    cpu_dout = r_rx;
            2'd1:    cpu_dout = {r_busy, r_ovr, sd_det, 4'b0000, r_ssel};
            2'd2:    cpu_dout = r_div;
            default: cpu_dout = 8'h00;
        endcase
    end

    // Software-owned registers: select, overrun flag and divider
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ssel <= 1'b1;
            r_ovr  <= 1'b0;
            r_div  <= RESET_DIV;
        end else begin
            if (w_wr_ctrl) begin
                r_ssel <= cpu_din[0];
                if (cpu_din[1])
                    r_ovr <= 1'b0;
            end
            if (w_wr_data && !w_idle)
                r_ovr <= 1'b1;
            if (w_wr_div && w_idle)
                r_div <= cpu_din;
        end
    end

    // Shift engine: alternating LOW/HIGH half-periods of div+1 clks
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_sclk  <= 1'b0;
            r_mosi  <= 1'b1;
            r_busy  <= 1'b0;
            r_rx    <= 8'hFF;
            r_rxsh  <= 8'hFF;
            r_tx    <= 8'h00;
            r_cnt   <= 8'h00;
            r_bit   <= 3'd0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    r_sclk <= 1'b0;
                    if (w_start) begin
                        r_tx    <= cpu_din;
                        r_mosi  <= cpu_din[7];
                        r_bit   <= 3'd0;
                        r_cnt   <= r_div;
                        r_busy  <= 1'b1;
                        r_state <= ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (r_cnt == 8'd0) begin
                        r_sclk  <= 1'b1;
                        r_rxsh  <= {r_rxsh[6:0], sd_miso};
                        r_cnt   <= r_div;
                        r_state <= ST_HIGH;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                ST_HIGH: begin
                    if (r_cnt == 8'd0) begin
                        r_sclk <= 1'b0;
                        r_bit  <= r_bit + 3'd1;
                        if (r_bit == 3'd7) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                            r_mosi  <= 1'b1;
                            r_rx    <= r_rxsh;
                        end else begin
                            r_tx    <= {r_tx[6:0], 1'b0};
                            r_mosi  <= r_tx[6];
                            r_cnt   <= r_div;
                            r_state <= ST_LOW;
                        end
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_sclk  <= 1'b0;
                    r_mosi  <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
